wdt_axi_regs: RTL
=================

// Module: wdt_axi_regs
// PURPOSE
// AXI4 slave register front-end for the watchdog timer, in the clk (CPU/bus) domain.
// Decodes bus writes into WDEN, WDLIVE and WTOCNT levels that drive the watchdog core.
// Captures the core's WTO level into a live/sticky status register for software.
// Sits between the AXI interconnect slave port and the WDT core.
// PARAMETERS
// ID_W       8   AXI ID width
// ADDR_W     32  AXI address width; only ADDR[11:0] decoded, upper bits ignored
// LIVE_HOLD  16  clk cycles WDLIVE stays high after a kick; must cover the core's 2-way CDC handshake
// PORTS
// clk        in   1       bus clock
// rst        in   1       asynchronous, active-high reset
// AW*        in/out       AWID[ID_W] AWADDR[ADDR_W] AWLEN[8] AWSIZE[3] AWBURST[2] AWVALID in; AWREADY out
// W*         in/out       WDATA[32] WSTRB[4] WLAST WVALID in; WREADY out
// B*         out/in       BID[ID_W] BRESP[2] BVALID out; BREADY in
// AR*        in/out       ARID[ID_W] ARADDR[ADDR_W] ARLEN[8] ARSIZE[3] ARBURST[2] ARVALID in; ARREADY out
// R*         out/in       RID[ID_W] RDATA[32] RRESP[2] RLAST RVALID out; RREADY in
// WTO        in   1       watchdog timeout level from core, already in clk domain
// WDEN       out  1       watchdog enable level to core
// WDLIVE     out  1       kick level to core, held LIVE_HOLD cycles
// WTOCNT     out  32      timeout count to core
// wto_irq    out  1       sticky timeout flag (interrupt request)
// BEHAVIOUR
// Register map (ADDR[11:0], word aligned; ADDR[1:0] ignored):
//  0x000 WDEN   RW  bit0; 0x004 WDLIVE RW bit0; 0x008 WTOCNT RW [31:0], byte strobes honoured
//  0x00C STAT   bit0 = WTO live (RO); bit1 = sticky (W1C); other bits read 0
//  Any other offset: DECERR (2'b11); writes have no effect; reads return 0
// Reset: all outputs, registers and counters 0; both FSMs idle; AWREADY=ARREADY=1 after reset.
// Write FSM W_IDLE -> W_DATA -> W_RESP:
//  - W_IDLE: AWREADY=1. AW handshake latches ID, addr, len -> W_DATA. WREADY=0.
//  - W_DATA: WREADY=1. Each W beat applies to the latched register, so the last beat wins per byte.
//    Register updates are visible on the outputs the cycle after the beat.
//    WLAST beat -> W_RESP. Response is OKAY for mapped addresses, DECERR otherwise.
//  - W_RESP: BVALID=1 with latched BID. Hold until BREADY, then W_IDLE. AWREADY=0 outside W_IDLE.
//  - WSTRB[0]=0 leaves WDEN/WDLIVE/STAT unaffected.
// Read FSM R_IDLE -> R_DATA:
//  - AR handshake latches ID, addr, len; RVALID=1 next cycle.
//  - Returns ARLEN+1 beats of the same register, sampled each beat. RLAST on the final beat.
//  - A beat advances only on RVALID&&RREADY; RDATA/RRESP stay stable while stalled.
//  - After the last beat -> R_IDLE.
//  - Read and write channels are fully independent and may be active together.
// WDLIVE:
//  - Writing bit0=1 loads the hold counter with LIVE_HOLD and drives WDLIVE=1.
//  - The counter decrements each cycle; WDLIVE falls the cycle the counter reaches 0.
//  - A re-kick during hold reloads the counter. Writing 0 is ignored. Readback = current WDLIVE.
// STAT sticky:
//  - Set on any cycle with WTO=1. W1C of bit1 clears it.
//  - Set wins over a clear in the same cycle. wto_irq = sticky bit.
// Simultaneous read and write of the same register: read returns the pre-write value.
// rst asserted mid-transaction: FSMs abort to idle, all VALIDs drop, registers clear.
//  - No response is issued for the aborted transaction.
// TESTING
// 1. Write 0x008=0x0000_1234 strb 4'hF; then write 0x008 data 0xAB00_0000 strb 4'h8
//    -> WTOCNT=0xAB00_1234; BRESP=OKAY; read 0x008 returns 0xAB00_1234.
// 2. Write 0x004=1 with LIVE_HOLD=16 -> WDLIVE high exactly 16 cycles.
//    Re-kick at cycle 10 -> high 16 cycles after the re-kick.
// 3. Drive WTO=1 for 3 cycles -> STAT reads 0x3, then 0x2 after WTO drops.
//    W1C 0x2 while WTO=1 -> stays set; W1C after WTO=0 -> STAT=0, wto_irq=0.
// 4. Write 0x020 and read 0x7FC -> BRESP/RRESP=DECERR, RDATA=0, no output change.
// 5. Read 0x000 with ARLEN=3 and RREADY toggling -> 4 beats, RLAST only on the 4th, RID echoed.
//    Write burst AWLEN=1 to 0x000 with data 1 then 0 -> WDEN=0, single B.
// 6. Assert rst while in W_RESP with BREADY=0 -> BVALID=0 and WDEN/WTOCNT=0 immediately.
//    New AW accepted after rst release.

Source files
------------

// File: rtl/wdt_axi_regs.sv
// AXI4 slave register front-end for the watchdog timer: WDEN/WDLIVE/WTOCNT control levels
// to the core and a live/sticky view of the core's timeout level.
module wdt_axi_regs #(
  parameter int ID_W      = 8,
  parameter int ADDR_W    = 32,
  parameter int LIVE_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [7:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  input  logic              WTO,
  output logic              WDEN,
  output logic              WDLIVE,
  output logic [31:0]       WTOCNT,
  output logic              wto_irq
);

  localparam int CW = $clog2(LIVE_HOLD + 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t           wstate_q;
  logic              awready_q, wready_q, bvalid_q;
  logic [ID_W-1:0]   bid_q;
  logic [1:0]        bresp_q;
  logic [11:0]       waddr_q;

  rstate_t           rstate_q;
  logic              arready_q, rvalid_q, rlast_q;
  logic [ID_W-1:0]   rid_q;
  logic [11:0]       raddr_q;
  logic [7:0]        rlen_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;

  logic              wden_q, wden_d;
  logic [31:0]       wtocnt_q, wtocnt_d;
  logic [CW-1:0]     live_cnt_q, live_cnt_d;
  logic              sticky_q, sticky_d;

  logic              wbeat, kick, w1c;
  logic [11:0]       rd_addr;
  logic [31:0]       rd_data;
  logic [1:0]        rd_resp;
  logic              unused_ok;

  function automatic logic addr_mapped(input logic [11:0] a);
    return a[11:4] == 8'h00;
  endfunction

  assign unused_ok = ^{AWADDR, ARADDR, AWLEN, AWSIZE, AWBURST, ARSIZE, ARBURST};

  assign wbeat = wready_q && WVALID;
  assign kick  = wbeat && addr_mapped(waddr_q) && (waddr_q[3:2] == 2'd1) && WSTRB[0] && WDATA[0];
  assign w1c   = wbeat && addr_mapped(waddr_q) && (waddr_q[3:2] == 2'd3) && WSTRB[0] && WDATA[1];

  always_comb begin
    wden_d   = wden_q;
    wtocnt_d = wtocnt_q;
    if (wbeat && addr_mapped(waddr_q) && (waddr_q[3:2] == 2'd0) && WSTRB[0]) wden_d = WDATA[0];
    for (int b = 0; b < 4; b++) begin
      if (wbeat && addr_mapped(waddr_q) && (waddr_q[3:2] == 2'd2) && WSTRB[b])
        wtocnt_d[8*b +: 8] = WDATA[8*b +: 8];
    end
    // A re-kick reloads the full hold time; otherwise count down to zero and stop.
    if (kick)                  live_cnt_d = CW'(LIVE_HOLD);
    else if (live_cnt_q != '0) live_cnt_d = live_cnt_q - 1'b1;
    else                       live_cnt_d = live_cnt_q;
    // A timeout seen in the same cycle as a clear keeps the flag set.
    if (WTO)      sticky_d = 1'b1;
    else if (w1c) sticky_d = 1'b0;
    else          sticky_d = sticky_q;
  end

  // Read mux sees pre-edge register state, so a same-cycle write is not yet visible.
  assign rd_addr = arready_q ? ARADDR[11:0] : raddr_q;

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (!addr_mapped(rd_addr)) begin
      rd_resp = RESP_DECERR;
    end else begin
      case (rd_addr[3:2])
        2'd0:    rd_data = {31'b0, wden_q};
        2'd1:    rd_data = {31'b0, WDLIVE};
        2'd2:    rd_data = wtocnt_q;
        default: rd_data = {30'b0, sticky_q, WTO};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wden_q     <= 1'b0;
      wtocnt_q   <= '0;
      live_cnt_q <= '0;
      sticky_q   <= 1'b0;
    end else begin
      wden_q     <= wden_d;
      wtocnt_q   <= wtocnt_d;
      live_cnt_q <= live_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  // ---- write channel: AW -> W beats -> B ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      waddr_q   <= '0;
    end else begin
      case (wstate_q)
        W_IDLE: if (AWVALID) begin
          bid_q     <= AWID;
          waddr_q   <= AWADDR[11:0];
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          wstate_q  <= W_DATA;
        end
        W_DATA: if (wbeat && WLAST) begin
          wready_q <= 1'b0;
          bvalid_q <= 1'b1;
          bresp_q  <= addr_mapped(waddr_q) ? RESP_OKAY : RESP_DECERR;
          wstate_q <= W_RESP;
        end
        W_RESP: if (BREADY) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          wstate_q  <= W_IDLE;
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // ---- read channel: AR -> ARLEN+1 beats of the same register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: if (ARVALID) begin
          rid_q     <= ARID;
          raddr_q   <= ARADDR[11:0];
          rlen_q    <= ARLEN;
          rdata_q   <= rd_data;
          rresp_q   <= rd_resp;
          rlast_q   <= (ARLEN == 8'd0);
          rvalid_q  <= 1'b1;
          arready_q <= 1'b0;
          rstate_q  <= R_DATA;
        end
        R_DATA: if (RREADY) begin
          if (rlast_q) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end else begin
            rlen_q  <= rlen_q - 8'd1;
            rlast_q <= (rlen_q == 8'd1);
            rdata_q <= rd_data;
            rresp_q <= rd_resp;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign WDEN    = wden_q;
  assign WDLIVE  = (live_cnt_q != '0);
  assign WTOCNT  = wtocnt_q;
  assign wto_irq = sticky_q;

endmodule
